lfsr_tap_search: RTL and testbench

Upstream controller for the LFSR tap lookup table. It scans tap indices 0..7, drives the table's 4-bit index input, and receives the 7-bit tap pattern back. For each tap it recovers a candidate seed from the first ciphertext byte, then checks the rest of a known-plaintext preamble against the LFSR keystream. It reports the first tap index that decrypts the whole preamble, plus the seed, to the decrypt datapath.

---
 rtl/lfsr_tap_search.sv | 246 ++++++++++++++++++++++++
 tb/tb_lfsr_tap_search.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_tap_search.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_tap_search
// Description : Finds which LFSR tap pattern, and which seed, produced a
//               block of ciphertext. Tap indices 0..7 are tried in ascending
//               order. For each one the candidate seed is taken from ciphertext
//               byte 0, and the remaining preamble bytes are checked against
//               the keystream. The search stops at the first index that
//               decrypts the whole preamble.
//
// Parameters  : PRE_LEN   - preamble length in bytes (2..64)
//               PRE_CHAR  - known plaintext character (bits [6:0] used)
//               BASE_ADDR - data-memory address of ciphertext byte 0
//
// Ports       : Clk       in   1  rising-edge clock
//               Reset     in   1  synchronous, active-low reset
//               Start     in   1  search request, accepted only in IDLE/DONE
//               MemAddr   out  8  ciphertext read address (registered)
//               MemData   in   8  read data, one cycle after MemAddr
//               TapIndex  out  4  tap LUT index (bit 3 always 0)
//               Tap       in   7  tap pattern, combinational from TapIndex
//               Busy      out  1  search in progress
//               Done      out  1  result valid, held until next Start/reset
//               Found     out  1  a tap index matched
//               FoundIdx  out  3  matching tap index (0 when not found)
//               Seed      out  7  recovered seed (0 when not found)
//
// Revision    : 1.0  initial release
// ============================================================================
module lfsr_tap_search #(
    parameter int unsigned PRE_LEN   = 10,
    parameter logic [7:0]  PRE_CHAR  = 8'h20,
    parameter logic [7:0]  BASE_ADDR = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic [7:0] MemAddr,
    input  logic [7:0] MemData,
    output logic [3:0] TapIndex,
    input  logic [6:0] Tap,
    output logic       Busy,
    output logic       Done,
    output logic       Found,
    output logic [2:0] FoundIdx,
    output logic [6:0] Seed
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH0 = 3'd1;
    localparam logic [2:0] c_ST_SEED   = 3'd2;
    localparam logic [2:0] c_ST_CHECK  = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam logic [6:0] c_PRE       = PRE_CHAR[6:0];
    // Index of the last preamble byte; PRE_LEN <= 64 so six bits suffice.
    localparam logic [5:0] c_LAST_IDX  = 6'(PRE_LEN - 1);
    localparam logic [2:0] c_LAST_TAP  = 3'd7;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_next_state;

    logic [6:0] r_lfsr;       // keystream state S for the byte being checked
    logic [6:0] r_cand;       // candidate seed for the tap under test
    logic [5:0] r_idx;        // index i of the byte being checked
    logic [2:0] r_tap_idx;
    logic [7:0] r_mem_addr;
    logic       r_found;
    logic [2:0] r_found_idx;
    logic [6:0] r_seed;

    logic       w_busy;
    logic       w_done;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [6:0] w_seed_cap;
    logic [6:0] w_next_lfsr;
    logic       w_match;
    logic       w_last_byte;
    logic       w_last_tap;
    logic [5:0] w_idx_inc;
    logic       w_unused_ok;

    assign w_seed_cap  = MemData[6:0] ^ c_PRE;
    assign w_next_lfsr = {r_lfsr[5:0], ^(r_lfsr & Tap)};
    assign w_match     = ((MemData[6:0] ^ w_next_lfsr) == c_PRE);
    assign w_last_byte = (r_idx == c_LAST_IDX);
    assign w_last_tap  = (r_tap_idx == c_LAST_TAP);
    assign w_idx_inc   = r_idx + 6'd1;

    // Ciphertext bit 7 carries no keystream information.
    assign w_unused_ok = MemData[7];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE,
            c_ST_DONE: begin
                if (Start) begin
                    w_next_state = c_ST_FETCH0;
                end
            end
            c_ST_FETCH0: begin
                w_next_state = c_ST_SEED;
            end
            c_ST_SEED: begin
                w_next_state = c_ST_CHECK;
            end
            c_ST_CHECK: begin
                if (w_match) begin
                    if (w_last_byte) begin
                        w_next_state = c_ST_DONE;
                    end
                end else if (w_last_tap) begin
                    w_next_state = c_ST_DONE;
                end else begin
                    w_next_state = c_ST_FETCH0;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_ST_FETCH0,
            c_ST_SEED,
            c_ST_CHECK: w_busy = 1'b1;
            c_ST_DONE:  w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    //
    // The memory returns data one cycle after the address is presented, so
    // the address for byte k is always presented while byte k-1 is being
    // consumed: BASE in FETCH0, BASE+1 in SEED, BASE+i+1 while checking
    // byte i. Once the last preamble address is reached it is held, so no
    // read ever goes past BASE_ADDR+PRE_LEN-1. All address sums wrap mod 256.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_lfsr      <= 7'd0;
            r_cand      <= 7'd0;
            r_idx       <= 6'd0;
            r_tap_idx   <= 3'd0;
            r_mem_addr  <= 8'd0;
            r_found     <= 1'b0;
            r_found_idx <= 3'd0;
            r_seed      <= 7'd0;
        end else begin
            case (r_state)
                c_ST_IDLE,
                c_ST_DONE: begin
                    if (Start) begin
                        r_tap_idx   <= 3'd0;
                        r_found     <= 1'b0;
                        r_found_idx <= 3'd0;
                        r_seed      <= 7'd0;
                        r_mem_addr  <= BASE_ADDR;
                    end
                end
                c_ST_FETCH0: begin
                    r_mem_addr <= BASE_ADDR + 8'd1;
                end
                c_ST_SEED: begin
                    r_lfsr <= w_seed_cap;
                    r_cand <= w_seed_cap;
                    r_idx  <= 6'd1;
                    // With a two-byte preamble byte 1 is already the last one.
                    if (c_LAST_IDX != 6'd1) begin
                        r_mem_addr <= BASE_ADDR + 8'd2;
                    end
                end
                c_ST_CHECK: begin
                    if (w_match) begin
                        if (w_last_byte) begin
                            r_found     <= 1'b1;
                            r_found_idx <= r_tap_idx;
                            r_seed      <= r_cand;
                        end else begin
                            r_lfsr <= w_next_lfsr;
                            r_idx  <= w_idx_inc;
                            if (w_idx_inc != c_LAST_IDX) begin
                                r_mem_addr <= r_mem_addr + 8'd1;
                            end
                        end
                    end else if (!w_last_tap) begin
                        r_tap_idx  <= r_tap_idx + 3'd1;
                        r_mem_addr <= BASE_ADDR;
                    end
                end
                default: begin
                    r_mem_addr <= r_mem_addr;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign MemAddr  = r_mem_addr;
    assign TapIndex = {1'b0, r_tap_idx};
    assign Busy     = w_busy;
    assign Done     = w_done;
    assign Found    = r_found;
    assign FoundIdx = r_found_idx;
    assign Seed     = r_seed;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_tap_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_tap_search
// Description : Self-checking bench for lfsr_tap_search. Two instances share
//               one clock and reset: one at base address 0x00, one at 0xFC
//               for the address-wrap case. A byte-array memory with one cycle
//               of read latency and a combinational tap LUT are modelled here.
//               Expected results come from a search model that walks the
//               ciphertext with the LFSR step function.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_tap_search;

    localparam int         L      = 10;
    localparam logic [6:0] PRE7   = 7'h20;
    localparam logic [7:0] BASE_B = 8'hFC;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start_a, start_b;
    logic [7:0] addr_a, addr_b, data_a, data_b, prev_a, prev_b;
    logic [3:0] tidx_a, tidx_b;
    logic [6:0] tap_a, tap_b, seed_a, seed_b;
    logic       busy_a, busy_b, done_a, done_b, found_a, found_b;
    logic [2:0] fidx_a, fidx_b;

    logic [7:0] mem [256];
    logic [6:0] lut [8];
    logic       sel;
    logic [7:0] trace [$];
    int         total = 0;
    int         bad   = 0;

    always #5 Clk = ~Clk;

    // Memory: data for the address presented in one cycle appears in the next.
    always @(posedge Clk) begin
        prev_a <= addr_a;
        prev_b <= addr_b;
    end
    assign data_a = mem[prev_a];
    assign data_b = mem[prev_b];
    assign tap_a  = lut[tidx_a[2:0]];
    assign tap_b  = lut[tidx_b[2:0]];

    lfsr_tap_search #(.PRE_LEN(L), .PRE_CHAR(8'h20), .BASE_ADDR(8'h00)) u_dut_a (
        .Clk(Clk), .Reset(Reset), .Start(start_a), .MemAddr(addr_a), .MemData(data_a),
        .TapIndex(tidx_a), .Tap(tap_a), .Busy(busy_a), .Done(done_a), .Found(found_a),
        .FoundIdx(fidx_a), .Seed(seed_a)
    );

    lfsr_tap_search #(.PRE_LEN(L), .PRE_CHAR(8'h20), .BASE_ADDR(BASE_B)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .Start(start_b), .MemAddr(addr_b), .MemData(data_b),
        .TapIndex(tidx_b), .Tap(tap_b), .Busy(busy_b), .Done(done_b), .Found(found_b),
        .FoundIdx(fidx_b), .Seed(seed_b)
    );

    // Selected-instance views
    logic       busy_s, done_s, found_s;
    logic [2:0] fidx_s;
    logic [6:0] seed_s;
    logic [7:0] addr_s;
    logic [3:0] tidx_s;
    assign busy_s  = sel ? busy_b  : busy_a;
    assign done_s  = sel ? done_b  : done_a;
    assign found_s = sel ? found_b : found_a;
    assign fidx_s  = sel ? fidx_b  : fidx_a;
    assign seed_s  = sel ? seed_b  : seed_a;
    assign addr_s  = sel ? addr_b  : addr_a;
    assign tidx_s  = sel ? tidx_b  : tidx_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    // Fill memory with noise, then place an encrypted preamble at base.
    task automatic load(input logic [7:0] base, input logic [6:0] tp, input logic [6:0] sd,
                        input bit flip7, input int corrupt);
        logic [6:0] s;
        logic [7:0] b;
        for (int j = 0; j < 256; j++) mem[j] = 8'($urandom);
        s = sd;
        for (int j = 0; j < L; j++) begin
            b = {flip7, PRE7 ^ s};
            if (j == corrupt) b[1] = ~b[1];
            mem[8'(base + 8'(j))] = b;
            s = step(s, tp);
        end
    endtask

    // Reference: try each tap in order; a tap rejected at byte j costs 2+j
    // cycles, a full match costs L+1.
    task automatic model(input logic [7:0] base, output logic f, output logic [2:0] idx,
                         output logic [6:0] sd, output int cyc);
        logic [6:0] s, s0;
        int         j;
        bit         ok;
        f = 1'b0; idx = 3'd0; sd = 7'd0; cyc = 0;
        for (int k = 0; k < 8; k++) begin
            if (!f) begin
                s0 = mem[base][6:0] ^ PRE7;
                s  = s0;
                ok = 1'b1;
                for (j = 1; j < L; j++) begin
                    s = step(s, lut[k]);
                    if ((mem[8'(base + 8'(j))][6:0] ^ s) != PRE7) begin
                        ok = 1'b0;
                        break;
                    end
                end
                if (ok) begin
                    f = 1'b1; idx = 3'(k); sd = s0; cyc += L + 1;
                end else begin
                    cyc += 2 + j;
                end
            end
        end
    endtask

    // Start the selected instance and wait for Done; edges counts rising
    // edges after the accepting one. A Start pulse is re-issued at poke.
    task automatic run(input bit s, input int poke, output logic f, output logic [2:0] idx,
                       output logic [6:0] sd, output int edges, output logic [3:0] ti);
        sel = s;
        trace.delete();
        @(negedge Clk);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge Clk);
        start_a = 1'b0; start_b = 1'b0;
        edges = 0;
        chk("busy_after_start", busy_s, 1);
        while (!done_s) begin
            if (edges >= 300) begin
                chk("done_timeout", done_s, 1);
                break;
            end
            if (trace.size() == 0 || trace[$] != addr_s) trace.push_back(addr_s);
            if (edges == poke) begin
                if (s) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            @(negedge Clk);
            edges++;
        end
        start_a = 1'b0; start_b = 1'b0;
        f = found_s; idx = fidx_s; sd = seed_s; ti = tidx_s;
    endtask

    typedef struct {
        bit         sel;
        logic [2:0] tidx;
        logic [6:0] seed;
        bit         flip7;
        int         corrupt;
        int         poke;
        logic       efound;
        logic [2:0] eidx;
        logic [6:0] eseed;
        int         eedges;   // -1: no fixed value, model only
        bit         etrace;   // check final pass reads base..base+L-1
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] base;
    logic       mf, df;
    logic [2:0] midx, didx;
    logic [6:0] mseed, dseed;
    int         medges, dedges, nmatch, rises;
    logic [3:0] dti;
    logic       last_done;

    initial begin
        lut[0] = 7'h40; lut[1] = 7'h08; lut[2] = 7'h20; lut[3] = 7'h72;
        lut[4] = 7'h01; lut[5] = 7'h02; lut[6] = 7'h04; lut[7] = 7'h7E;
        for (int j = 0; j < 256; j++) mem[j] = 8'h00;

        //              sel tidx  seed  f7 corr poke  F  idx  seed  edges trace
        vecs[0] = '{1'b0, 3'd3, 7'h15, 1'b0, -1, -1, 1'b1, 3'd3, 7'h15, 20, 1'b0};
        vecs[1] = '{1'b0, 3'd0, 7'h01, 1'b0, -1, -1, 1'b1, 3'd0, 7'h01, 11, 1'b1};
        vecs[2] = '{1'b0, 3'd0, 7'h01, 1'b0,  1, -1, 1'b0, 3'd0, 7'h00, 24, 1'b0};
        vecs[3] = '{1'b1, 3'd7, 7'h7F, 1'b0, -1, -1, 1'b1, 3'd7, 7'h7F, -1, 1'b1};
        vecs[4] = '{1'b0, 3'd3, 7'h15, 1'b0, -1,  5, 1'b1, 3'd3, 7'h15, 20, 1'b0};
        vecs[5] = '{1'b0, 3'd3, 7'h15, 1'b1, -1, -1, 1'b1, 3'd3, 7'h15, 20, 1'b0};

        sel = 1'b0; start_a = 1'b0; start_b = 1'b0; Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_memaddr", addr_a, 0);
        chk("rst_tapindex", tidx_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_found", {found_a, fidx_a, seed_a}, 0);
        Reset = 1'b1;
        @(negedge Clk);

        // Directed table
        for (int n = 0; n < 6; n++) begin
            base = vecs[n].sel ? BASE_B : 8'h00;
            load(base, lut[vecs[n].tidx], vecs[n].seed, vecs[n].flip7, vecs[n].corrupt);
            model(base, mf, midx, mseed, medges);
            run(vecs[n].sel, vecs[n].poke, df, didx, dseed, dedges, dti);
            chk("found", df, mf);
            chk("found_idx", didx, midx);
            chk("seed", dseed, mseed);
            chk("done_edges", dedges, medges);
            chk("tap_index", dti, mf ? {1'b0, midx} : 4'd7);
            chk("found_fixed", df, vecs[n].efound);
            chk("found_idx_fixed", didx, vecs[n].eidx);
            chk("seed_fixed", dseed, vecs[n].eseed);
            if (vecs[n].eedges >= 0) chk("done_edges_fixed", dedges, vecs[n].eedges);
            if (vecs[n].etrace) begin
                nmatch = 0;
                if (trace.size() >= L) begin
                    for (int j = 0; j < L; j++)
                        if (trace[trace.size() - L + j] == 8'(base + 8'(j))) nmatch++;
                end
                chk("addr_seq", nmatch, L);
            end
            repeat (3) @(negedge Clk);
            chk("done_hold", done_s, 1);
            chk("busy_in_done", busy_s, 0);
            chk("found_hold", found_s, df);
        end

        // Reset in the middle of a search: outputs clear, no Done appears.
        load(8'h00, lut[3], 7'h15, 1'b0, -1);
        sel = 1'b0;
        @(negedge Clk); start_a = 1'b1;
        @(negedge Clk); start_a = 1'b0;
        repeat (6) @(negedge Clk);
        chk("busy_before_abort", busy_a, 1);
        Reset = 1'b0;
        @(negedge Clk);
        chk("abort_memaddr", addr_a, 0);
        chk("abort_tapindex", tidx_a, 0);
        chk("abort_busy_done", {busy_a, done_a}, 0);
        chk("abort_result", {found_a, fidx_a, seed_a}, 0);
        chk("abort_other_inst", {found_b, fidx_b, seed_b, done_b}, 0);
        Reset = 1'b1;
        rises = 0; last_done = done_a;
        repeat (40) begin
            @(negedge Clk);
            if (done_a && !last_done) rises++;
            last_done = done_a;
        end
        chk("no_done_after_abort", rises, 0);

        // Start together with reset: reset wins.
        Reset = 1'b0; start_a = 1'b1;
        @(negedge Clk);
        Reset = 1'b1; start_a = 1'b0;
        @(negedge Clk);
        chk("reset_beats_start", busy_a, 0);

        // Randomized ciphertexts and tap tables
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < 8; k++) lut[k] = 7'($urandom);
            sel  = 1'($urandom_range(0, 1));
            base = sel ? BASE_B : 8'h00;
            load(base, lut[$urandom_range(0, 7)], 7'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 14)));
            model(base, mf, midx, mseed, medges);
            run(sel, -1, df, didx, dseed, dedges, dti);
            chk("rnd_found", df, mf);
            chk("rnd_found_idx", didx, midx);
            chk("rnd_seed", dseed, mseed);
            chk("rnd_done_edges", dedges, medges);
            chk("rnd_tap_index", dti, mf ? {1'b0, midx} : 4'd7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
